// File: rtl/pe_array_stream_pkg.sv
// Shared types and defaults for the pe_array_stream systolic tile engine.
package pe_array_stream_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ROWS       = 16;
   localparam int DEF_COLS       = 16;
   localparam int DEF_K_MAX      = 256;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_READ  = 2'd3
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/pe_array_stream_pe.sv
// One processing element: signed MAC, right/down operand forwarding, clear,
// and a shift path that moves the accumulator one column toward column 0.
module pe_acc_cell #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_W      = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clr,
   input  logic                  i_run,
   input  logic                  i_shift,
   input  logic [DATA_WIDTH-1:0] i_left,
   input  logic [DATA_WIDTH-1:0] i_top,
   input  logic [ACC_W-1:0]      i_acc_in,
   output logic [DATA_WIDTH-1:0] o_right,
   output logic [DATA_WIDTH-1:0] o_down,
   output logic [ACC_W-1:0]      o_acc
);

   logic signed [2*DATA_WIDTH-1:0] w_l_ext;
   logic signed [2*DATA_WIDTH-1:0] w_t_ext;
   logic signed [2*DATA_WIDTH-1:0] w_prod;
   logic        [ACC_W-1:0]        w_prod_ext;
   logic        [DATA_WIDTH-1:0]   r_right;
   logic        [DATA_WIDTH-1:0]   r_down;
   logic        [ACC_W-1:0]        r_acc;

   assign w_l_ext    = (2*DATA_WIDTH)'($signed(i_left));
   assign w_t_ext    = (2*DATA_WIDTH)'($signed(i_top));
   assign w_prod     = w_l_ext * w_t_ext;
   assign w_prod_ext = ACC_W'(w_prod);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_right <= '0;
         r_down  <= '0;
         r_acc   <= '0;
      end else if (i_clr) begin
         r_right <= '0;
         r_down  <= '0;
         r_acc   <= '0;
      end else if (i_run) begin
         r_right <= i_left;
         r_down  <= i_top;
         r_acc   <= r_acc + w_prod_ext;
      end else if (i_shift) begin
         r_acc   <= i_acc_in;
      end
   end

   assign o_right = r_right;
   assign o_down  = r_down;
   assign o_acc   = r_acc;

endmodule

// File: rtl/pe_array_stream.sv
// Output-stationary ROWS x COLS systolic MAC array with streamed operands and
// column-serial result readout. Define PE_ARRAY_STREAM_RELU_EN to clamp negative results to 0.
module pe_array_stream
   import pe_array_stream_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int ROWS       = DEF_ROWS,
   parameter  int COLS       = DEF_COLS,
   parameter  int K_MAX      = DEF_K_MAX,
   localparam int ACC_W      = 2*DATA_WIDTH + clog2(K_MAX),
   localparam int KW         = clog2(K_MAX + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [KW-1:0]              k_len,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [COLS*DATA_WIDTH-1:0] wgt_in,
   input  logic [ROWS*DATA_WIDTH-1:0] ifm_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ROWS*ACC_W-1:0]      ofm_out,
   output logic                       busy,
   output logic                       done
);

   localparam int DCW = clog2(ROWS + COLS);
   localparam int BCW = clog2(COLS + 1);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [KW-1:0]  r_klen;
   logic [KW-1:0]  r_kcnt;
   logic [DCW-1:0] r_dcnt;
   logic [BCW-1:0] r_bcnt;
   logic           r_done;

   logic w_clr, w_run, w_hs, w_shift, w_last, w_in_ready, w_out_valid, w_busy;

   logic [DATA_WIDTH-1:0] w_ifm_lane     [ROWS];
   logic [DATA_WIDTH-1:0] w_wgt_lane     [COLS];
   logic [DATA_WIDTH-1:0] w_left         [ROWS][COLS+1];
   logic [DATA_WIDTH-1:0] w_top          [ROWS+1][COLS];
   logic [ACC_W-1:0]      w_acc          [ROWS][COLS+1];
   logic [DATA_WIDTH-1:0] w_unused_right [ROWS];
   logic [DATA_WIDTH-1:0] w_unused_down  [COLS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_run       = 1'b0;
      w_hs        = 1'b0;
      w_shift     = 1'b0;
      w_last      = 1'b0;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (start && (k_len != '0) && (k_len <= KW'(K_MAX))) begin
               w_clr       = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_in_ready = 1'b1;
            w_run      = 1'b1;
            w_hs       = in_valid;
            if (in_valid && (r_kcnt == r_klen - KW'(1))) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            w_run = 1'b1;
            if (r_dcnt == DCW'(ROWS + COLS - 2)) w_state_nxt = S_READ;
         end
         S_READ: begin
            w_out_valid = 1'b1;
            if (out_ready) begin
               w_shift = 1'b1;
               if (r_bcnt == BCW'(COLS - 1)) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_klen <= '0;
         r_kcnt <= '0;
         r_dcnt <= '0;
         r_bcnt <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_clr) begin
            r_klen <= k_len;
            r_kcnt <= '0;
            r_dcnt <= '0;
            r_bcnt <= '0;
         end
         if (w_hs)                r_kcnt <= r_kcnt + KW'(1);
         if (r_state == S_DRAIN)  r_dcnt <= r_dcnt + DCW'(1);
         if (w_shift)             r_bcnt <= r_bcnt + BCW'(1);
      end
   end

   // Lane k is delayed k cycles so operands of one beat meet at PE(i,j) on cycle i+j.
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_ifm
      assign w_ifm_lane[gi] = w_hs ? ifm_in[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (gi == 0) begin : g_direct
         assign w_left[gi][0] = w_ifm_lane[gi];
      end else begin : g_skew
         logic [DATA_WIDTH-1:0] r_sk [gi];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned k = 0; k < gi; k++) r_sk[k] <= '0;
            end else if (w_clr) begin
               for (int unsigned k = 0; k < gi; k++) r_sk[k] <= '0;
            end else if (w_run) begin
               r_sk[0] <= w_ifm_lane[gi];
               for (int unsigned k = 1; k < gi; k++) r_sk[k] <= r_sk[k-1];
            end
         end
         assign w_left[gi][0] = r_sk[gi-1];
      end
   end

   for (genvar gj = 0; gj < COLS; gj++) begin : g_wgt
      assign w_wgt_lane[gj] = w_hs ? wgt_in[gj*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (gj == 0) begin : g_direct
         assign w_top[0][gj] = w_wgt_lane[gj];
      end else begin : g_skew
         logic [DATA_WIDTH-1:0] r_sk [gj];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned k = 0; k < gj; k++) r_sk[k] <= '0;
            end else if (w_clr) begin
               for (int unsigned k = 0; k < gj; k++) r_sk[k] <= '0;
            end else if (w_run) begin
               r_sk[0] <= w_wgt_lane[gj];
               for (int unsigned k = 1; k < gj; k++) r_sk[k] <= r_sk[k-1];
            end
         end
         assign w_top[0][gj] = r_sk[gj-1];
      end
      assign w_unused_down[gj] = w_top[ROWS][gj];
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
         pe_acc_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_W      (ACC_W)
         ) u_pe (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_clr    (w_clr),
            .i_run    (w_run),
            .i_shift  (w_shift),
            .i_left   (w_left[gi][gj]),
            .i_top    (w_top[gi][gj]),
            .i_acc_in (w_acc[gi][gj+1]),
            .o_right  (w_left[gi][gj+1]),
            .o_down   (w_top[gi+1][gj]),
            .o_acc    (w_acc[gi][gj])
         );
      end
      assign w_acc[gi][COLS]  = '0;
      assign w_unused_right[gi] = w_left[gi][COLS];
`ifdef PE_ARRAY_STREAM_RELU_EN
      assign ofm_out[gi*ACC_W +: ACC_W] = w_acc[gi][0][ACC_W-1] ? '0 : w_acc[gi][0];
`else
      assign ofm_out[gi*ACC_W +: ACC_W] = w_acc[gi][0];
`endif
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign busy      = w_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_pe_array_stream.sv
// Self-checking bench for pe_array_stream: matrix-product reference model plus
// a per-cycle compare process on the result stream and done pulse.
module tb_pe_array_stream;

   localparam int DW    = 8;
   localparam int ROWS  = 16;
   localparam int COLS  = 16;
   localparam int K_MAX = 256;
   localparam int ACC_W = 24;
   localparam int KW    = 9;
   localparam int BW    = ROWS * ACC_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [KW-1:0]     k_len;
   logic              in_valid;
   logic              in_ready;
   logic [COLS*DW-1:0] wgt_in;
   logic [ROWS*DW-1:0] ifm_in;
   logic              out_valid;
   logic              out_ready;
   logic [BW-1:0]     ofm_out;
   logic              busy;
   logic              done;

   pe_array_stream #(
      .DATA_WIDTH (DW),
      .ROWS       (ROWS),
      .COLS       (COLS),
      .K_MAX      (K_MAX)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k_len     (k_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wgt_in    (wgt_in),
      .ifm_in    (ifm_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ofm_out   (ofm_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int s_ifm [K_MAX][ROWS];
   int s_wgt [K_MAX][COLS];
   logic [ACC_W-1:0] exp_m [COLS][ROWS];

   int mon_beat  = 0;
   bit done_pend = 1'b0;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: C = A^T * W over the tile's beats, truncated to ACC_W.
   task automatic compute_exp(input int k);
      for (int j = 0; j < COLS; j++) begin
         for (int i = 0; i < ROWS; i++) begin
            longint acc;
            acc = 0;
            for (int b = 0; b < k; b++) acc += longint'(s_ifm[b][i]) * longint'(s_wgt[b][j]);
`ifdef PE_ARRAY_STREAM_RELU_EN
            if (acc < 0) acc = 0;
`endif
            exp_m[j][i] = acc[ACC_W-1:0];
         end
      end
   endtask

   function automatic logic [BW-1:0] exp_bus(input int c);
      logic [BW-1:0] v;
      v = '0;
      for (int i = 0; i < ROWS; i++) v[i*ACC_W +: ACC_W] = exp_m[c][i];
      return v;
   endfunction

   task automatic fill_const(input int k, input int fi, input int fw);
      for (int b = 0; b < k; b++) begin
         for (int i = 0; i < ROWS; i++) s_ifm[b][i] = fi;
         for (int j = 0; j < COLS; j++) s_wgt[b][j] = fw;
      end
   endtask

   task automatic fill_rand(input int k);
      for (int b = 0; b < k; b++) begin
         for (int i = 0; i < ROWS; i++) s_ifm[b][i] = int'($urandom_range(0, 255)) - 128;
         for (int j = 0; j < COLS; j++) s_wgt[b][j] = int'($urandom_range(0, 255)) - 128;
      end
   endtask

   task automatic drive_beat(input int b);
      for (int i = 0; i < ROWS; i++) ifm_in[i*DW +: DW] = DW'(s_ifm[b][i]);
      for (int j = 0; j < COLS; j++) wgt_in[j*DW +: DW] = DW'(s_wgt[b][j]);
   endtask

   task automatic drive_junk();
      for (int i = 0; i < ROWS; i++) ifm_in[i*DW +: DW] = DW'($urandom);
      for (int j = 0; j < COLS; j++) wgt_in[j*DW +: DW] = DW'($urandom);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_beat  = 0;
         done_pend = 1'b0;
      end else begin
         check("done_pulse", BW'(done), BW'(done_pend));
         done_pend = 1'b0;
         if (out_valid) begin
            check($sformatf("ofm_beat%0d", mon_beat), ofm_out, exp_bus(mon_beat));
            if (out_ready) begin
               if (mon_beat == COLS - 1) begin
                  done_pend = 1'b1;
                  mon_beat  = 0;
               end else begin
                  mon_beat++;
               end
            end
         end
      end
   end

   task automatic load_tile(input int k, input int gap_mode, output bit ok);
      int guard;
      bit acc;
      ok = 1'b1;
      start = 1'b1;
      k_len = KW'(k);
      @(posedge clk); #1;
      start = 1'b0;
      check("start_accept", BW'({busy, in_ready, out_valid}), BW'(3'b110));
      for (int b = 0; b < k; b++) begin
         drive_beat(b);
         in_valid = 1'b1;
         guard = 0;
         do begin
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
         end while (!acc && guard < 50);
         if (!acc) begin
            check("beat_timeout", BW'(0), BW'(1));
            in_valid = 1'b0;
            ok = 1'b0;
            return;
         end
         if (b < k - 1 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
            in_valid = 1'b0;
            drive_junk();
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic read_tile(input int stall_beat, input int stall_len, input bit rnd);
      for (int c = 0; c < COLS; c++) begin
         int st;
         st = (c == stall_beat) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
         out_ready = 1'b0;
         repeat (st) begin @(posedge clk); #1; end
         out_ready = 1'b1;
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
   endtask

   task automatic run_tile(input int k, input int gap_mode, input int stall_beat,
                           input int stall_len, input bit rnd_ready);
      int guard;
      bit bad_ready;
      bit ok;
      load_tile(k, gap_mode, ok);
      if (!ok) return;
      in_valid = 1'b1;
      drive_junk();
      guard = 0;
      bad_ready = 1'b0;
      while (!out_valid && guard < 200) begin
         if (in_ready) bad_ready = 1'b1;
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0;
      check("drain_cycles", BW'(guard), BW'(ROWS + COLS - 1));
      check("in_ready_low_drain", BW'(bad_ready), BW'(0));
      read_tile(stall_beat, stall_len, rnd_ready);
      check("tile_end", BW'({done, busy, out_valid, in_ready}), BW'(4'b1000));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      bit bad;
      rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
      ifm_in = '0; wgt_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", BW'({in_ready, out_valid, done, busy}), BW'(0));
      check("reset_ofm", ofm_out, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_ctrl", BW'({in_ready, out_valid, done, busy}), BW'(0));

      // 2-lane product on a 16x16 array: remaining lanes zero.
      fill_const(1, 0, 0);
      s_ifm[0][0] = 1; s_ifm[0][1] = 2; s_wgt[0][0] = 3; s_wgt[0][1] = 4;
      compute_exp(1);
      check("pin_b0r0", BW'(exp_m[0][0]), BW'(24'd3));
      check("pin_b0r1", BW'(exp_m[0][1]), BW'(24'd6));
      check("pin_b1r0", BW'(exp_m[1][0]), BW'(24'd4));
      check("pin_b1r1", BW'(exp_m[1][1]), BW'(24'd8));
      run_tile(1, 0, -1, 0, 1'b0);

      fill_const(3, 1, 1);
      compute_exp(3);
      check("pin_ones", BW'(exp_m[5][7]), BW'(24'd3));
      run_tile(3, 1, -1, 0, 1'b0);

      fill_const(K_MAX, -128, -128);
      compute_exp(K_MAX);
      check("pin_kmax", BW'(exp_m[15][15]), BW'(24'd4194304));
      run_tile(K_MAX, 0, -1, 0, 1'b0);

      fill_rand(5);
      compute_exp(5);
      run_tile(5, 0, 2, 5, 1'b0);

      fill_const(2, 1, -5);
      compute_exp(2);
`ifdef PE_ARRAY_STREAM_RELU_EN
      check("pin_relu", BW'(exp_m[3][4]), BW'(24'd0));
`else
      check("pin_neg", BW'(exp_m[3][4]), BW'(24'hFFFFF6));
`endif
      run_tile(2, 0, -1, 0, 1'b0);

      start = 1'b1; k_len = 9'd0;
      @(posedge clk); #1;
      check("ignore_k0", BW'({busy, in_ready}), BW'(0));
      k_len = 9'd257;
      @(posedge clk); #1;
      check("ignore_k257", BW'({busy, in_ready}), BW'(0));
      k_len = 9'h1FF;
      @(posedge clk); #1;
      start = 1'b0;
      check("ignore_k511", BW'({busy, in_ready}), BW'(0));

      fill_rand(4);
      compute_exp(4);
      load_tile(4, 0, ok);
      repeat (5) begin @(posedge clk); #1; end
      check("mid_drain_busy", BW'({busy, out_valid}), BW'(2'b10));
      #2 rst_n = 1'b0;
      #1;
      check("reset_async_ctrl", BW'({in_ready, out_valid, done, busy}), BW'(0));
      check("reset_async_ofm", ofm_out, '0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid || busy || done) bad = 1'b1;
      end
      check("idle_after_reset", BW'(bad), BW'(0));
      fill_rand(1);
      compute_exp(1);
      run_tile(1, 0, -1, 0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         int k;
         k = int'($urandom_range(1, 12));
         fill_rand(k);
         compute_exp(k);
         run_tile(k, 2, -1, 0, 1'b1);
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pe_array_stream.md
PE_ARRAY_STREAM -- requirements
Module: pe_array_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed operand width.
REQ-002 SHALL have parameter ROWS, default 16, array rows (ifm lanes, output lanes).
REQ-003 SHALL have parameter COLS, default 16, array columns (wgt lanes, output beats).
REQ-004 SHALL have parameter K_MAX, default 256, maximum MAC steps per tile.
REQ-005 SHALL have local ACC_W = 2*DATA_WIDTH + clog2(K_MAX) and KW = clog2(K_MAX+1).
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, one-cycle tile start, sampled only in IDLE.
REQ-009 SHALL have port k_len, input, KW, MAC steps for the tile, latched on accepted start.
REQ-010 SHALL have port in_valid / in_ready, input / output, 1 each, operand-beat handshake.
REQ-011 SHALL have port wgt_in, input, COLS*DATA_WIDTH, lane j at [j*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port ifm_in, input, ROWS*DATA_WIDTH, lane i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port out_valid / out_ready, output / input, 1 each, result-beat handshake.
REQ-014 SHALL have port ofm_out, output, ROWS*ACC_W, row i at [i*ACC_W +: ACC_W].
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse after the last result beat is accepted.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> DRAIN -> READ -> IDLE.
REQ-018 IDLE: start=1 with k_len in 1..K_MAX SHALL clear all accumulators and enter LOAD; start with k_len=0 or k_len>K_MAX SHALL be ignored.
REQ-019 LOAD: in_ready=1; each in_valid&in_ready beat SHALL count, and after the k_len-th beat the FSM SHALL enter DRAIN.
REQ-020 Internal skew SHALL delay ifm lane i by i cycles and wgt lane j by j cycles; it SHALL shift every cycle, injecting zeros on cycles without a handshake.
REQ-021 PE(i,j) SHALL accumulate signed left*top every cycle in LOAD/DRAIN, forwarding operands right/down with one-cycle registers.
REQ-022 DRAIN SHALL last exactly ROWS+COLS-1 cycles; out_valid SHALL rise ROWS+COLS-1 cycles after the clock edge that accepted the last beat.
REQ-023 READ SHALL present COLS beats, column 0 first; beat c carries acc(i,c) for all rows; accumulators SHALL shift one column toward column 0 per accepted beat.
REQ-024 out_valid=1 with out_ready=0 SHALL hold ofm_out and the accumulators stable.
REQ-025 After beat COLS-1 is accepted: done=1 for one cycle, FSM in IDLE the same cycle.
REQ-026 in_ready SHALL be 0 outside LOAD; in_valid outside LOAD SHALL be ignored.
REQ-027 Accumulation SHALL be full precision; wrap modulo 2^ACC_W only if K_MAX is exceeded, which cannot happen per REQ-018.

Reset
REQ-028 rst_n low SHALL force: FSM IDLE, counters 0, skew and PE registers 0, in_ready=0, out_valid=0, done=0, busy=0, ofm_out=0.
REQ-029 Reset asserted mid-tile SHALL abandon the tile with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-030 With PE_ARRAY_STREAM_RELU_EN defined, every ofm_out row value SHALL be replaced by 0 when negative; without it, raw signed accumulators SHALL be output.

Structure
REQ-031 Package pe_array_stream_pkg SHALL hold the FSM state enum, a clog2 function, and default parameter constants.
REQ-032 The PE SHALL be a sub-module pe_acc_cell (MAC, operand forward registers, clear, shift-left accumulator path).

Verification
REQ-033 2x2, k_len=1, ifm={1,2}, wgt={3,4} -> beat0 rows {3,6}, beat1 {4,8}, done after beat1.
REQ-034 16x16, k_len=3, all operands 1, in_valid gaps every other cycle -> every output 3; out_valid exactly 31 cycles after the last beat.
REQ-035 ifm=-128, wgt=-128, k_len=K_MAX=256 -> each output 4194304, no wrap at ACC_W=24.
REQ-036 out_ready low for 5 cycles on beat 2 -> ofm_out stable, beats 3..COLS-1 correct after release.
REQ-037 rst_n pulsed during DRAIN -> outputs 0, no done; next tile with k_len=1 is bit-exact.
REQ-038 With RELU_EN, ifm=1, wgt=-5, k_len=2 -> outputs 0; without it -> -10.
